rco_calib_ctrl: RTL and testbench
=================================

// Module: rco_calib_ctrl
// PURPOSE
//   Successive-approximation calibration controller for the 7-bit trimmed RC oscillator.
//   Enables the RCO and binary-searches calib_word, one bit per trial, MSB first.
//   Each trial counts RCO rising edges over a fixed window of system clocks and compares the count to target_cnt.
//   Sits in the system clock domain. Drives the RCO calib_word/clk_en pins and samples the RCO clock as data.
//   RCO frequency falls as calib_word rises.
// PARAMETERS
//   WORD_W      7      calibration word width (SAR steps)
//   CNT_W       16     edge-counter / target width; counter saturates at all-ones
//   EN_WAIT     400    clk cycles from rco_en rise to first trial (RCO enable delay)
//   SETTLE_CYC  2000   clk cycles after each calib_word change before measuring
//   WIN_CYC     20000  measurement window length in clk cycles
// PORTS
//   clk         in   1       system clock, >= 4x max RCO frequency (200 MHz nominal)
//   rst_n       in   1       asynchronous active-low reset
//   start       in   1       1-cycle pulse: begin calibration (ignored while busy)
//   abort       in   1       level: stop calibration, return to IDLE
//   target_cnt  in   CNT_W   required RCO edges per window; sampled on accepted start
//   rco_clk_in  in   1       RCO clock, asynchronous, treated as data
//   calib_word  out  WORD_W  trim word to RCO
//   rco_en      out  1       RCO clk_en
//   busy        out  1       high from accepted start until DONE or abort
//   done        out  1       level: result valid; cleared by next accepted start
//   no_clk      out  1       set if any window counts 0 edges; cleared on accepted start
//   meas_cnt    out  CNT_W   edge count of last completed window
// BEHAVIOUR
//   Reset: IDLE; calib_word=7'h40; rco_en=0; busy=done=no_clk=0; meas_cnt=0; sync flops=0.
//   Edge detect: 2-flop synchronizer plus one delay flop; rise = s2 & ~s3.
//     Synchronizer runs in every state. Only rises that occur in MEASURE are counted.
//   FSM:
//     IDLE: on start & ~abort: latch target, busy=1, done=0, no_clk=0, rco_en=1, bit=WORD_W-1 -> ENWAIT.
//     ENWAIT: wait EN_WAIT cycles -> TRIAL.
//     TRIAL (1 cyc): calib_word[bit]=1, bits below bit=0, bits above unchanged -> SETTLE.
//     SETTLE: wait SETTLE_CYC cycles; clear edge counter -> MEASURE.
//     MEASURE: exactly WIN_CYC cycles.
//       Counter += rise each cycle, saturating at 2^CNT_W-1.
//       A rise in the final cycle is counted.
//     DECIDE (1 cyc): meas_cnt<=count; if count==0 set no_clk.
//       If count > target: keep bit=1 (RCO too fast). Else (including equal): clear bit.
//       If bit==0 -> DONE, else bit-- -> TRIAL.
//     DONE: busy=0, done=1, rco_en stays 1, calib_word holds the result -> IDLE on the same cycle.
//       A later start restarts the search from 7'h40.
//   Latency, start to done: 1 + EN_WAIT + WORD_W*(1+SETTLE_CYC+WIN_CYC+1) cycles.
//   Abort (any busy state): next cycle IDLE, rco_en=0, busy=0, done=0.
//     calib_word holds its current value. meas_cnt holds. abort overrides start.
//   start while busy: ignored; target is not re-latched.
//   rst_n assert mid-search: all outputs immediately take reset values; no resume.
//   rco_clk_in stuck at 0 or 1: every count is 0, so all bits clear -> calib_word=0, no_clk=1, done=1.
//   target_cnt=0 with RCO running: every bit kept -> 7'h7F.
//   target_cnt=all-ones: no count exceeds it -> 7'h00.
// TESTING (200 MHz clk, defaults, RCO model f = 10 MHz + (128-w)*320.3125 kHz)
//   1 Nominal, target_cnt=3000 (30 MHz): trial words 64,96,80,72,68,66,65; kept bits at 64 and 65.
//     -> calib_word=65, meas_cnt~3018, done=1 at start+1+400+7*22002 cycles.
//   2 target_cnt=0 -> calib_word=7'h7F. target_cnt=16'hFFFF -> 7'h00. Both: no_clk=0.
//   3 rco_clk_in tied 0 -> calib_word=0, no_clk=1, meas_cnt=0, done=1.
//   4 abort during 3rd trial MEASURE -> next cycle rco_en=0, busy=0, done=0, calib_word=7'h50.
//     New start then completes normally.
//   5 start pulsed again mid-search with target 1000 -> ignored; result still 65 (original target 3000).
//   6 rst_n low during SETTLE -> calib_word=7'h40, rco_en=0, busy=0 asynchronously.
//     After release, fresh start gives scenario-1 result.

Source files
------------

// File: rtl/rco_calib_ctrl.sv
// Successive-approximation trim controller for the RC oscillator: one calib_word bit
// per trial, MSB first, decided by counting synchronized RCO rising edges over a window.
module rco_calib_ctrl #(
    parameter int WORD_W     = 7,
    parameter int CNT_W      = 16,
    parameter int EN_WAIT    = 400,
    parameter int SETTLE_CYC = 2000,
    parameter int WIN_CYC    = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  target_cnt,
    input  logic              rco_clk_in,
    output logic [WORD_W-1:0] calib_word,
    output logic              rco_en,
    output logic              busy,
    output logic              done,
    output logic              no_clk,
    output logic [CNT_W-1:0]  meas_cnt
);

    localparam int TMR_MAX = (EN_WAIT > SETTLE_CYC)
                           ? ((EN_WAIT > WIN_CYC) ? EN_WAIT : WIN_CYC)
                           : ((SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [WORD_W-1:0] WORD_INIT = {1'b1, {(WORD_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, ENWAIT, TRIAL, SETTLE, MEASURE, DECIDE, DONE
    } state_t;

    state_t              state_reg;
    logic [TMR_W-1:0]    timer_reg;
    logic [BIT_W-1:0]    bit_reg;
    logic [CNT_W-1:0]    target_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;
    logic [WORD_W-1:0]   calib_word_reg;
    logic [WORD_W-1:0]   trial_word;
    logic                rco_en_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                no_clk_reg;
    logic [CNT_W-1:0]    meas_cnt_reg;
    logic                s1_reg, s2_reg, s3_reg;
    logic                rise;

    // RCO clock is sampled as plain data; s3 delays s2 by one cycle for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= rco_clk_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign rise     = s2_reg & ~s3_reg;
    assign cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(rise);

    // Trial word: bit under test set, lower bits cleared, already-decided upper bits kept
    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_trial
            assign trial_word[gi] = (BIT_W'(gi) == bit_reg) ? 1'b1 :
                                    (BIT_W'(gi) >  bit_reg) ? calib_word_reg[gi] : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            bit_reg        <= '0;
            target_reg     <= '0;
            cnt_reg        <= '0;
            calib_word_reg <= WORD_INIT;
            rco_en_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            no_clk_reg     <= 1'b0;
            meas_cnt_reg   <= '0;
        end else if (abort && state_reg != IDLE) begin
            state_reg  <= IDLE;
            rco_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        target_reg <= target_cnt;
                        busy_reg   <= 1'b1;
                        done_reg   <= 1'b0;
                        no_clk_reg <= 1'b0;
                        rco_en_reg <= 1'b1;
                        bit_reg    <= BIT_W'(WORD_W - 1);
                        timer_reg  <= TMR_W'(EN_WAIT - 1);
                        state_reg  <= ENWAIT;
                    end
                end
                ENWAIT: begin
                    if (timer_reg == '0) begin
                        state_reg <= TRIAL;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                TRIAL: begin
                    calib_word_reg <= trial_word;
                    timer_reg      <= TMR_W'(SETTLE_CYC - 1);
                    state_reg      <= SETTLE;
                end
                SETTLE: begin
                    cnt_reg <= '0;
                    if (timer_reg == '0) begin
                        timer_reg <= TMR_W'(WIN_CYC - 1);
                        state_reg <= MEASURE;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                MEASURE: begin
                    cnt_reg <= cnt_next;
                    if (timer_reg == '0) begin
                        state_reg <= DECIDE;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                DECIDE: begin
                    meas_cnt_reg <= cnt_reg;
                    if (cnt_reg == '0) begin
                        no_clk_reg <= 1'b1;
                    end
                    // Higher word means slower RCO, so a fast count keeps the bit set
                    if (!(cnt_reg > target_reg)) begin
                        calib_word_reg[bit_reg] <= 1'b0;
                    end
                    if (bit_reg == '0) begin
                        state_reg <= DONE;
                    end else begin
                        bit_reg   <= bit_reg - 1'b1;
                        state_reg <= TRIAL;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign calib_word = calib_word_reg;
    assign rco_en     = rco_en_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign no_clk     = no_clk_reg;
    assign meas_cnt   = meas_cnt_reg;

endmodule

// File: tb/tb_rco_calib_ctrl.sv
// Directed bench for rco_calib_ctrl with shortened timing and a behavioural RCO whose
// frequency follows calib_word; window length 8 us keeps the 65/66 decision well separated.
`timescale 1ns/1ps
module tb_rco_calib_ctrl;

    localparam int WORD_W     = 7;
    localparam int CNT_W      = 16;
    localparam int EN_WAIT    = 16;
    localparam int SETTLE_CYC = 16;
    localparam int WIN_CYC    = 1600;
    localparam int LATENCY    = 1 + EN_WAIT + WORD_W * (1 + SETTLE_CYC + WIN_CYC + 1);
    localparam int TIMEOUT    = LATENCY + 500;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  target_cnt = '0;
    logic              rco_clk_in = 1'b0;
    logic [WORD_W-1:0] calib_word;
    logic              rco_en;
    logic              busy;
    logic              done;
    logic              no_clk;
    logic [CNT_W-1:0]  meas_cnt;

    bit rco_stuck = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    rco_calib_ctrl #(
        .WORD_W(WORD_W), .CNT_W(CNT_W), .EN_WAIT(EN_WAIT),
        .SETTLE_CYC(SETTLE_CYC), .WIN_CYC(WIN_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .target_cnt(target_cnt), .rco_clk_in(rco_clk_in),
        .calib_word(calib_word), .rco_en(rco_en), .busy(busy),
        .done(done), .no_clk(no_clk), .meas_cnt(meas_cnt)
    );

    always #2.5 clk = ~clk;

    // RCO model: f = 10 MHz + (128 - w) * 320.3125 kHz
    initial begin : rco_model
        real f_mhz;
        forever begin
            if (rco_stuck) begin
                rco_clk_in = 1'b0;
                #5;
            end else begin
                f_mhz = 10.0 + real'(128 - int'(calib_word)) * 0.3203125;
                #(500.0 / f_mhz) rco_clk_in = ~rco_clk_in;
            end
        end
    end

    task automatic start_cal(input logic [CNT_W-1:0] tgt);
        @(posedge clk); #1;
        target_cnt = tgt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        $display("run target=%0d word=%h meas=%0d no_clk=%b cycles=%0d",
                 target_cnt, calib_word, meas_cnt, no_clk, n);
    endtask

    task automatic wait_word(input logic [WORD_W-1:0] w, output int n);
        n = 0;
        while (calib_word !== w && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (calib_word !== 7'h40) begin miscompares++; $display("FAIL reset_word got %h want 40", calib_word); end
        vectors++; if (rco_en !== 1'b0) begin miscompares++; $display("FAIL reset_rco_en got %b want 0", rco_en); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (no_clk !== 1'b0) begin miscompares++; $display("FAIL reset_no_clk got %b want 0", no_clk); end
        vectors++; if (meas_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_meas got %0d want 0", meas_cnt); end
    endtask

    task automatic test_nominal();
        int n;
        start_cal(16'd240);
        vectors++; if (busy !== 1'b1 || rco_en !== 1'b1 || done !== 1'b0) begin
            miscompares++; $display("FAIL nom_accept got busy=%b en=%b done=%b want 1 1 0", busy, rco_en, done);
        end
        wait_done(n);
        vectors++; if (n !== LATENCY) begin miscompares++; $display("FAIL nom_latency got %0d want %0d", n, LATENCY); end
        vectors++; if (calib_word !== 7'd65) begin miscompares++; $display("FAIL nom_word got %0d want 65", calib_word); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nom_busy got %b want 0", busy); end
        vectors++; if (rco_en !== 1'b1) begin miscompares++; $display("FAIL nom_rco_en got %b want 1", rco_en); end
        vectors++; if (no_clk !== 1'b0) begin miscompares++; $display("FAIL nom_no_clk got %b want 0", no_clk); end
        vectors++; if (meas_cnt < 16'd240 || meas_cnt > 16'd243) begin
            miscompares++; $display("FAIL nom_meas got %0d want 240..243", meas_cnt);
        end
    endtask

    task automatic test_target_extremes();
        int n;
        start_cal(16'd0);
        wait_done(n);
        vectors++; if (calib_word !== 7'h7F) begin miscompares++; $display("FAIL t0_word got %h want 7f", calib_word); end
        vectors++; if (no_clk !== 1'b0) begin miscompares++; $display("FAIL t0_no_clk got %b want 0", no_clk); end
        vectors++; if (meas_cnt < 16'd81 || meas_cnt > 16'd84) begin
            miscompares++; $display("FAIL t0_meas got %0d want 81..84", meas_cnt);
        end
        start_cal(16'hFFFF);
        wait_done(n);
        vectors++; if (calib_word !== 7'h00) begin miscompares++; $display("FAIL tmax_word got %h want 00", calib_word); end
        vectors++; if (no_clk !== 1'b0) begin miscompares++; $display("FAIL tmax_no_clk got %b want 0", no_clk); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL tmax_done got %b want 1", done); end
    endtask

    task automatic test_no_clk();
        int n;
        rco_stuck = 1'b1;
        start_cal(16'd240);
        wait_done(n);
        vectors++; if (calib_word !== 7'h00) begin miscompares++; $display("FAIL stuck_word got %h want 00", calib_word); end
        vectors++; if (no_clk !== 1'b1) begin miscompares++; $display("FAIL stuck_no_clk got %b want 1", no_clk); end
        vectors++; if (meas_cnt !== 16'd0) begin miscompares++; $display("FAIL stuck_meas got %0d want 0", meas_cnt); end
        vectors++; if (done !== 1'b1 || n !== LATENCY) begin
            miscompares++; $display("FAIL stuck_done got done=%b cycles=%0d want 1 %0d", done, n, LATENCY);
        end
        rco_stuck = 1'b0;
    endtask

    task automatic test_abort();
        int n;
        start_cal(16'd240);
        vectors++; if (no_clk !== 1'b0) begin miscompares++; $display("FAIL abort_noclk_clear got %b want 0", no_clk); end
        wait_word(7'h50, n);
        vectors++; if (n >= TIMEOUT) begin miscompares++; $display("FAIL abort_reach_trial3 got timeout want word 50"); end
        repeat (SETTLE_CYC + 20) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        vectors++; if (rco_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL abort_flags got en=%b busy=%b done=%b want 0 0 0", rco_en, busy, done);
        end
        vectors++; if (calib_word !== 7'h50) begin miscompares++; $display("FAIL abort_word got %h want 50", calib_word); end
        // meas_cnt holds trial-2 result (word 0x60, 20.25 MHz over 8 us)
        vectors++; if (meas_cnt < 16'd161 || meas_cnt > 16'd163) begin
            miscompares++; $display("FAIL abort_meas got %0d want 161..163", meas_cnt);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (busy !== 1'b0 || rco_en !== 1'b0) begin
            miscompares++; $display("FAIL abort_over_start got busy=%b en=%b want 0 0", busy, rco_en);
        end
        abort = 1'b0;
        $display("abort word=%h", calib_word);
    endtask

    task automatic test_start_while_busy();
        int n;
        start_cal(16'd240);
        repeat (3000) @(posedge clk);
        #1;
        target_cnt = 16'd1000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        vectors++; if (calib_word !== 7'd65) begin miscompares++; $display("FAIL busy_start_word got %0d want 65", calib_word); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL busy_start_done got %b want 1", done); end
    endtask

    task automatic test_reset_mid();
        int n;
        start_cal(16'd240);
        wait_word(7'h60, n);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #0.5;
        vectors++; if (calib_word !== 7'h40) begin miscompares++; $display("FAIL rst_mid_word got %h want 40", calib_word); end
        vectors++; if (rco_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_flags got en=%b busy=%b want 0 0", rco_en, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_no_resume got busy=%b want 0", busy); end
        start_cal(16'd240);
        wait_done(n);
        vectors++; if (calib_word !== 7'd65 || n !== LATENCY) begin
            miscompares++; $display("FAIL rst_rerun got word=%0d cycles=%0d want 65 %0d", calib_word, n, LATENCY);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_target_extremes();
        test_no_clk();
        test_abort();
        test_start_while_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
